imm_decode_stage: RTL and testbench

//  Registered, parametrised immediate-decode pipeline stage: extracts and sign/zero-extends the RV32I/RV64I immediate.

---
 rtl/imm_decode_pkg.sv | 29 ++
 rtl/imm_decode_stage_extract.sv | 89 ++++++++
 rtl/imm_decode_stage.sv | 75 +++++++
 tb/tb_imm_decode_stage.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/imm_decode_pkg.sv
// Shared opcodes, immediate-format codes and the packed entry width for the imm_decode stage.
// Optional feature macro: IMM_DECODE_CSR_EN (CSR zimm immediates).
`define IMM_DECODE_ENTRY_W(xlen, tagw) (3*(xlen) + 3 + (tagw))

package imm_decode_pkg;

  localparam logic [6:0] LOAD      = 7'b0000011;
  localparam logic [6:0] STORE     = 7'b0100011;
  localparam logic [6:0] BRANCH    = 7'b1100011;
  localparam logic [6:0] JAL       = 7'b1101111;
  localparam logic [6:0] JALR      = 7'b1100111;
  localparam logic [6:0] LUI       = 7'b0110111;
  localparam logic [6:0] AUIPC     = 7'b0010111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] SYSTEM    = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_SH   = 3'd6,
    FMT_Z    = 3'd7
  } fmt_e;

endpackage

// File: rtl/imm_decode_stage_extract.sv
// Combinational RV32I/RV64I immediate extraction and format classification.
// Optional feature macro: IMM_DECODE_CSR_EN.
module imm_extract
  import imm_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output fmt_e            fmt
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh, imm_sh5;

  assign opcode  = instr[6:0];
  assign funct3  = instr[14:12];
  assign imm_i   = XLEN'($signed(instr[31:20]));
  assign imm_s   = XLEN'($signed({instr[31:25], instr[11:7]}));
  assign imm_b   = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
  assign imm_j   = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
  assign imm_u   = XLEN'($signed({instr[31:12], 12'h000}));
  assign imm_sh5 = XLEN'(instr[24:20]);
  assign imm_sh  = (XLEN == 64) ? XLEN'(instr[25:20]) : imm_sh5;

`ifdef IMM_DECODE_CSR_EN
  logic [XLEN-1:0] imm_z;
  assign imm_z = XLEN'(instr[19:15]);
`endif

  always_comb begin
    imm = '0;
    fmt = FMT_NONE;
    case (opcode)
      OP_IMM: begin
        if (funct3[1:0] == 2'b01) begin
          imm = imm_sh;
          fmt = FMT_SH;
        end else begin
          imm = imm_i;
          fmt = FMT_I;
        end
      end
      LOAD, JALR: begin
        imm = imm_i;
        fmt = FMT_I;
      end
      STORE: begin
        imm = imm_s;
        fmt = FMT_S;
      end
      BRANCH: begin
        imm = imm_b;
        fmt = FMT_B;
      end
      JAL: begin
        imm = imm_j;
        fmt = FMT_J;
      end
      LUI, AUIPC: begin
        imm = imm_u;
        fmt = FMT_U;
      end
      OP_IMM_32: begin
        // Word shifts keep a 5-bit shamt even on RV64.
        if (XLEN == 64) begin
          if (funct3[1:0] == 2'b01) begin
            imm = imm_sh5;
            fmt = FMT_SH;
          end else begin
            imm = imm_i;
            fmt = FMT_I;
          end
        end
      end
`ifdef IMM_DECODE_CSR_EN
      SYSTEM: begin
        if (funct3[2]) begin
          imm = imm_z;
          fmt = FMT_Z;
        end
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode stage with pc+imm precompute and a 2-entry (output + skid) elastic buffer.
// Optional feature macro: IMM_DECODE_CSR_EN (passed through to imm_extract).
module imm_decode_stage
  import imm_decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [31:0]      instr_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [XLEN-1:0]  imm_o,
  output logic [2:0]       fmt_o,
  output logic [XLEN-1:0]  target_o,
  output logic [XLEN-1:0]  pc_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam int EW = `IMM_DECODE_ENTRY_W(XLEN, TAG_W);

  logic [XLEN-1:0] imm;
  fmt_e            fmt;
  logic [EW-1:0]   in_entry, out_entry, skid_entry;
  logic            out_valid, skid_valid;
  logic            acc_in, out_free;

  imm_extract #(.XLEN(XLEN)) u_extract (
    .instr (instr_i),
    .imm   (imm),
    .fmt   (fmt)
  );

  assign in_entry = {imm, fmt, pc_i + imm, pc_i, tag_i};
  assign acc_in   = valid_i && ready_o;
  assign out_free = !out_valid || ready_i;

  // ready_o is low whenever skid is occupied, so acc_in never coincides with skid refill into output.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_entry  <= '0;
      skid_entry <= '0;
    end else if (flush_i) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (out_free) begin
      if (skid_valid) begin
        out_entry  <= skid_entry;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else if (acc_in) begin
        out_entry <= in_entry;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (acc_in) begin
      skid_entry <= in_entry;
      skid_valid <= 1'b1;
    end
  end

  assign {imm_o, fmt_o, target_o, pc_o, tag_o} = out_entry;
  assign valid_o = out_valid;
  assign ready_o = !skid_valid;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed self-checking bench for imm_decode_stage (XLEN=32 and XLEN=64 instances).
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        valid, ready_in;
  logic [31:0] instr, pc;
  logic [3:0]  tag;
  logic        valid_out, ready_out;
  logic [31:0] imm_out, target_out, pc_out;
  logic [2:0]  fmt_out;
  logic [3:0]  tag_out;

  logic        valid64, ready64_out, valid64_out;
  logic [31:0] instr64;
  logic [63:0] pc64, imm64_out, target64_out, pc64_out;
  logic [2:0]  fmt64_out;
  logic [3:0]  tag64_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imm_decode_stage #(.XLEN(32), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .flush_i(flush), .valid_i(valid), .ready_o(ready_out),
    .instr_i(instr), .pc_i(pc), .tag_i(tag), .valid_o(valid_out), .ready_i(ready_in),
    .imm_o(imm_out), .fmt_o(fmt_out), .target_o(target_out), .pc_o(pc_out), .tag_o(tag_out)
  );

  imm_decode_stage #(.XLEN(64), .TAG_W(4)) dut64 (
    .clk(clk), .rst(rst), .flush_i(1'b0), .valid_i(valid64), .ready_o(ready64_out),
    .instr_i(instr64), .pc_i(pc64), .tag_i(4'd0), .valid_o(valid64_out), .ready_i(1'b1),
    .imm_o(imm64_out), .fmt_o(fmt64_out), .target_o(target64_out), .pc_o(pc64_out), .tag_o(tag64_out)
  );

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; valid = 1'b0; ready_in = 1'b1;
    instr = '0; pc = '0; tag = '0;
    valid64 = 1'b0; instr64 = '0; pc64 = '0;
    step(); step();
    rst = 1'b0;

    check("rst_valid", 64'(valid_out), 64'd0);
    check("rst_ready", 64'(ready_out), 64'd1);
    check("rst_imm", 64'(imm_out), 64'd0);
    check("rst_fmt", 64'(fmt_out), 64'd0);
    check("rst_target", 64'(target_out), 64'd0);
    check("rst_pc_tag", 64'({pc_out, tag_out}), 64'd0);

    // addi x1,x0,-1
    valid = 1'b1; instr = 32'hFFF00093; pc = 32'h0; tag = 4'd5;
    step();
    valid = 1'b0;
    check("addi_valid", 64'(valid_out), 64'd1);
    check("addi_imm", 64'(imm_out), 64'hFFFFFFFF);
    check("addi_fmt", 64'(fmt_out), 64'd1);
    check("addi_target", 64'(target_out), 64'hFFFFFFFF);
    check("addi_tag", 64'(tag_out), 64'd5);

    valid = 1'b1; instr = 32'hFE000EE3; pc = 32'h100; tag = 4'd6;
    step();
    valid = 1'b0;
    check("beq_imm", 64'(imm_out), 64'hFFFFFFFC);
    check("beq_fmt", 64'(fmt_out), 64'd3);
    check("beq_target", 64'(target_out), 64'h000000FC);
    step();
    check("drain_valid", 64'(valid_out), 64'd0);

    // sw x1,-8(x2)
    valid = 1'b1; instr = 32'hFE112C23; pc = 32'h40; tag = 4'd1;
    step();
    check("sw_imm", 64'(imm_out), 64'hFFFFFFF8);
    check("sw_fmt", 64'(fmt_out), 64'd2);
    // jal x0,+8
    instr = 32'h0080006F; pc = 32'h200;
    step();
    check("jal_imm", 64'(imm_out), 64'h8);
    check("jal_fmt", 64'(fmt_out), 64'd5);
    check("jal_target", 64'(target_out), 64'h208);
    // srai x1,x1,1: shamt must not pick up funct7
    instr = 32'h4010D093; pc = 32'h0;
    step();
    check("srai_imm", 64'(imm_out), 64'h1);
    check("srai_fmt", 64'(fmt_out), 64'd6);
    // addiw is not a valid RV32 opcode
    instr = 32'h0010809B;
    step();
    check("addiw32_imm", 64'(imm_out), 64'h0);
    check("addiw32_fmt", 64'(fmt_out), 64'd0);
    instr = 32'h00000033;
    step();
    check("rtype_fmt", 64'({imm_out, fmt_out}), 64'd0);
    instr = 32'h3001D073;
    step();
`ifdef IMM_DECODE_CSR_EN
    check("csrrwi_imm", 64'(imm_out), 64'h3);
    check("csrrwi_fmt", 64'(fmt_out), 64'd7);
`else
    check("csrrwi_imm", 64'(imm_out), 64'h0);
    check("csrrwi_fmt", 64'(fmt_out), 64'd0);
`endif
    valid = 1'b0;
    step();

    // RV64 instance
    valid64 = 1'b1; instr64 = 32'h800000B7; pc64 = 64'h1000;
    step();
    check("lui64_imm", imm64_out, 64'hFFFFFFFF80000000);
    check("lui64_fmt", 64'(fmt64_out), 64'd4);
    check("lui64_target", target64_out, 64'hFFFFFFFF80001000);
    instr64 = 32'h03F09093;
    step();
    check("slli64_imm", imm64_out, 64'h3F);
    check("slli64_fmt", 64'(fmt64_out), 64'd6);
    instr64 = 32'h03F0909B;
    step();
    check("slliw64_imm", imm64_out, 64'h1F);
    check("slliw64_fmt", 64'(fmt64_out), 64'd6);
    instr64 = 32'h0010809B;
    step();
    check("addiw64_imm", imm64_out, 64'h1);
    check("addiw64_fmt", 64'(fmt64_out), 64'd1);
    valid64 = 1'b0;
    step();
    check("drain64_valid", 64'(valid64_out), 64'd0);

    // Backpressure: three beats against a stalled output
    ready_in = 1'b0; valid = 1'b1; instr = 32'hFFF00093;
    tag = 4'd1; pc = 32'h4;
    step();
    check("bp1_ready", 64'(ready_out), 64'd1);
    check("bp1_tag", 64'(tag_out), 64'd1);
    tag = 4'd2; pc = 32'h8;
    step();
    check("bp2_ready", 64'(ready_out), 64'd0);
    check("bp2_tag", 64'(tag_out), 64'd1);
    tag = 4'd3; pc = 32'hC;
    step();
    check("bp3_ready", 64'(ready_out), 64'd0);
    check("bp3_hold", 64'({valid_out, tag_out, pc_out}), {27'd0, 1'b1, 4'd1, 32'h4});
    ready_in = 1'b1;
    step();
    check("rel1_tag", 64'({valid_out, tag_out, pc_out}), {27'd0, 1'b1, 4'd2, 32'h8});
    check("rel1_ready", 64'(ready_out), 64'd1);
    step();
    valid = 1'b0;
    check("rel2_tag", 64'({valid_out, tag_out, pc_out}), {27'd0, 1'b1, 4'd3, 32'hC});
    step();
    check("rel3_valid", 64'(valid_out), 64'd0);

    // Flush with skid full and a beat offered
    ready_in = 1'b0; valid = 1'b1;
    tag = 4'd7;
    step();
    tag = 4'd8;
    step();
    check("pre_flush_ready", 64'(ready_out), 64'd0);
    flush = 1'b1; tag = 4'd9;
    step();
    flush = 1'b0;
    check("flush_valid", 64'(valid_out), 64'd0);
    check("flush_ready", 64'(ready_out), 64'd1);
    ready_in = 1'b1; tag = 4'd10;
    step();
    valid = 1'b0;
    check("post_flush_tag", 64'({valid_out, tag_out}), {59'd0, 1'b1, 4'd10});
    step();
    check("post_flush_drain", 64'(valid_out), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
